// File: rtl/key_mode_ctrl_if.sv
// Bundles the button/switch inputs and the mode outputs of key_mode_ctrl.
//   key_n    : raw push-button, 0 = pressed, asynchronous
//   sw       : raw mode switches, asynchronous
//   mode     : current mode code (0-3 switch modes, F = pause)
//   mode_stb : one-cycle pulse when mode takes a new value
//   pressed  : debounced button level, 1 = held
interface key_mode_ctrl_if;
  logic       key_n;
  logic [1:0] sw;
  logic [3:0] mode;
  logic       mode_stb;
  logic       pressed;

  // Stimulus side drives the raw inputs.
  modport master (
    output key_n,
    output sw,
    input  mode,
    input  mode_stb,
    input  pressed
  );

  // Controller side.
  modport slave (
    input  key_n,
    input  sw,
    output mode,
    output mode_stb,
    output pressed
  );
endinterface

// File: rtl/key_mode_ctrl.sv
// Synchronizes and debounces the push-button and mode switches, loads the
// switch value into the mode register on a confirmed press, and issues the
// pause code after a long continuous hold.
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : key_mode_ctrl_if.slave (key_n, sw in; mode, mode_stb, pressed out)
module key_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 10000000
) (
  input  logic            clock,
  input  logic            reset,
  key_mode_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nx;
  logic                long_done, long_done_nx;
  logic [3:0]          mode_q, mode_nx;
  logic                stb_q, stb_nx;
  logic                pressed_q, pressed_nx;

  logic                key_m, key_s;
  logic [1:0]          sw_m, sw_s;
  logic                press;

  assign press = ~key_s;

  // State, counters, outputs and two-flop synchronizers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_cnt  <= '0;
      long_done <= 1'b0;
      mode_q    <= 4'h0;
      stb_q     <= 1'b0;
      pressed_q <= 1'b0;
      key_m     <= 1'b1;
      key_s     <= 1'b1;
      sw_m      <= 2'b00;
      sw_s      <= 2'b00;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      hold_cnt  <= hold_cnt_nx;
      long_done <= long_done_nx;
      mode_q    <= mode_nx;
      stb_q     <= stb_nx;
      pressed_q <= pressed_nx;
      key_m     <= bus.key_n;
      key_s     <= key_m;
      sw_m      <= bus.sw;
      sw_s      <= sw_m;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    hold_cnt_nx  = hold_cnt;
    long_done_nx = long_done;
    mode_nx      = mode_q;
    stb_nx       = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (press) state_nx = PRESS_DB;
      end
      PRESS_DB: begin
        if (!press) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_nx     = HELD;
          cnt_nx       = '0;
          mode_nx      = {2'b00, sw_s};
          stb_nx       = 1'b1;
          hold_cnt_nx  = '0;
          long_done_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        // A release sample wins over the long-press threshold.
        if (!press) begin
          state_nx = RELEASE_DB;
          cnt_nx   = '0;
        end else begin
          if (hold_cnt != HOLD_W'(LONG_CYCLES)) hold_cnt_nx = hold_cnt + HOLD_W'(1);
          if (hold_cnt == HOLD_W'(LONG_CYCLES - 1) && !long_done) begin
            mode_nx      = 4'hF;
            stb_nx       = 1'b1;
            long_done_nx = 1'b1;
          end
        end
      end
      RELEASE_DB: begin
        // hold_cnt/long_done kept so a glitch does not restart long-press timing.
        if (press) begin
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    pressed_nx = (state_nx == HELD) || (state_nx == RELEASE_DB);
  end

  assign bus.mode     = mode_q;
  assign bus.mode_stb = stb_q;
  assign bus.pressed  = pressed_q;

endmodule
